serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx.sv | 132 +++++++++++++
 tb/tb_serial_frame_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends a 4-bit preamble followed by a DATA_W-bit payload (MSB first) on J.
// Optional even-parity bit after the payload when SERIAL_TX_PARITY_EN is defined.
module serial_frame_tx #(
  parameter logic [3:0] PREAMBLE = 4'b1101,
  parameter int         DATA_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] DataIn,
  output logic              J,
  output logic              Busy,
  output logic              Done
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] DLAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    FIN
  } state_t;

  state_t            state, state_d;
  logic [1:0]        pcnt, pcnt_d;
  logic [CW-1:0]     dcnt, dcnt_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              j_d, busy_d, done_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      pcnt  <= '0;
      dcnt  <= '0;
      sh    <= '0;
    end else begin
      state <= state_d;
      pcnt  <= pcnt_d;
      dcnt  <= dcnt_d;
      sh    <= sh_d;
    end
  end

  // The payload is rotated rather than shifted, so after DATA_W bits it is
  // back in its original form and still available for the parity bit.
  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    dcnt_d  = dcnt;
    sh_d    = sh;
    case (state)
      IDLE, FIN: begin
        if (Start) begin
          state_d = PRE;
          pcnt_d  = '0;
          dcnt_d  = '0;
          sh_d    = DataIn;
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (pcnt == 2'd3) begin
          state_d = DATA;
          dcnt_d  = '0;
        end else begin
          pcnt_d = pcnt + 2'd1;
        end
      end
      DATA: begin
        sh_d = {sh[DATA_W-2:0], sh[DATA_W-1]};
        if (dcnt == DLAST) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = FIN;
`endif
        end else begin
          dcnt_d = dcnt + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: state_d = FIN;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-cycle values and then registered,
  // so they line up with the state they describe without any path from Start.
  always_comb begin
    j_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      PRE: begin
        j_d    = PREAMBLE[~pcnt_d];
        busy_d = 1'b1;
      end
      DATA: begin
        j_d    = sh_d[DATA_W-1];
        busy_d = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        j_d    = ^sh_d;
        busy_d = 1'b1;
      end
`endif
      FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      J    <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      J    <= j_d;
      Busy <= busy_d;
      Done <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: expected {J,Busy,Done} per cycle are queued
// when a request is driven and popped one per clock cycle.
module tb_serial_frame_tx;

  localparam logic [3:0] PRE_PAT = 4'b1101;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 13;
`else
  localparam int FL = 12;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [7:0] DataIn;
  logic       J, Busy, Done;

  logic [2:0] exp_q[$];
  int         checks = 0;
  int         passes = 0;

  serial_frame_tx #(.PREAMBLE(4'b1101), .DATA_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .DataIn(DataIn),
    .J(J), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic push_frame(input logic [7:0] d);
    for (int i = 3; i >= 0; i--) exp_q.push_back({PRE_PAT[i], 1'b1, 1'b0});
    for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b0});
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back({^d, 1'b1, 1'b0});
`endif
    exp_q.push_back(3'b001);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
  endtask

  task automatic check_now(input string tag, input logic [2:0] e);
    checks++;
    assert ({J, Busy, Done} === e) begin
      passes++;
    end else begin
      $error("FAIL %s: {J,Busy,Done}=%b expected %b", tag, {J, Busy, Done}, e);
    end
  endtask

  task automatic tick(input string tag);
    logic [2:0] e;
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s: {J,Busy,Done}=%b expected <none queued>", tag, {J, Busy, Done});
    end else begin
      e = exp_q.pop_front();
      check_now(tag, e);
    end
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; DataIn = '0;
    #3;
    check_now("reset_hold", 3'b000);
    @(posedge Clk); #1;
    check_now("reset_hold_edge", 3'b000);
    Rst = 1'b1;

    // Idle line
    push_idle(20);
    repeat (20) tick("idle");

    // Single frame
    Start = 1'b1; DataIn = 8'hA5;
    push_frame(8'hA5);
    tick("single");
    Start = 1'b0; DataIn = '0;
    repeat (FL) tick("single");
    push_idle(2);
    repeat (2) tick("single_after");

    // Ignored request during the 3rd DATA cycle
    Start = 1'b1; DataIn = 8'hA5;
    push_frame(8'hA5);
    tick("ignored");
    Start = 1'b0;
    repeat (6) tick("ignored");
    Start = 1'b1; DataIn = 8'hFF;
    tick("ignored");
    Start = 1'b0; DataIn = '0;
    repeat (FL - 7) tick("ignored");
    push_idle(2);
    repeat (2) tick("ignored_after");

    // Back-to-back frames
    Start = 1'b1; DataIn = 8'h3C;
    push_frame(8'h3C);
    tick("b2b_first");
    Start = 1'b0;
    repeat (FL) tick("b2b_first");
    Start = 1'b1; DataIn = 8'hC3;
    push_frame(8'hC3);
    tick("b2b_second");
    Start = 1'b0; DataIn = '0;
    repeat (FL) tick("b2b_second");
    push_idle(2);
    repeat (2) tick("b2b_after");

    // Reset asserted in the 2nd DATA cycle
    Start = 1'b1; DataIn = 8'h96;
    push_frame(8'h96);
    tick("rst_frame");
    Start = 1'b0;
    repeat (5) tick("rst_frame");
    #2;
    Rst = 1'b0;
    #1;
    check_now("rst_async", 3'b000);
    exp_q.delete();
    @(posedge Clk); #1;
    check_now("rst_held", 3'b000);
    Rst = 1'b1;
    Start = 1'b1; DataIn = 8'h01;
    push_frame(8'h01);
    tick("post_rst");
    Start = 1'b0; DataIn = '0;
    repeat (FL) tick("post_rst");
    push_idle(2);
    repeat (2) tick("post_rst_after");

`ifdef SERIAL_TX_PARITY_EN
    Start = 1'b1; DataIn = 8'h07;
    push_frame(8'h07);
    tick("parity_07");
    Start = 1'b0;
    repeat (FL) tick("parity_07");
    push_idle(1);
    tick("parity_gap");
    Start = 1'b1; DataIn = 8'h03;
    push_frame(8'h03);
    tick("parity_03");
    Start = 1'b0; DataIn = '0;
    repeat (FL) tick("parity_03");
    push_idle(2);
    repeat (2) tick("parity_after");
`endif

    checks++;
    assert (exp_q.size() == 0) begin
      passes++;
    end else begin
      $error("FAIL queue_drained: left=%0d expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
